// File: rtl/cycle_sequencer.sv
// Microcycle sequencer: drives the decoder's cycle index and handles run/step/halt
// control plus hand-off of the shared bus to an external program loader.

`ifndef STATE_NEXT
`define STATE_NEXT 4'hE
`endif
`ifndef STATE_HALT
`define STATE_HALT 4'hF
`endif

module cycle_sequencer #(
  parameter int                  CYCLE_W   = 4,
  parameter int                  MAX_CYCLE = 7,
  parameter int                  STATE_W   = 4,
  parameter logic [STATE_W-1:0]  ST_NEXT   = `STATE_NEXT,
  parameter logic [STATE_W-1:0]  ST_HALT   = `STATE_HALT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  input  logic               step,
  input  logic [STATE_W-1:0] state_in,
  input  logic               ld_req,
  output logic [CYCLE_W-1:0] cycle,
  output logic               cycle_en,
  output logic               instr_done,
  output logic               halted,
  output logic               ld_gnt,
  output logic               seq_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_HALTED = 3'd3,
    S_LOAD   = 3'd4
  } state_t;

  localparam logic [CYCLE_W-1:0] LP_MAX_CYCLE = CYCLE_W'(MAX_CYCLE);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CYCLE_W-1:0] r_cycle;
  logic [CYCLE_W-1:0] w_cycle_nxt;
  logic               r_cycle_en;
  logic               r_instr_done;
  logic               r_halted;
  logic               r_ld_gnt;
  logic               r_seq_err;
  logic               w_instr_done_nxt;
  logic               w_seq_err_nxt;
  logic               w_at_max;
  logic               w_exec_nxt;

  assign w_at_max = (r_cycle == LP_MAX_CYCLE);

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_cycle_nxt      = r_cycle;
    w_instr_done_nxt = 1'b0;
    w_seq_err_nxt    = r_seq_err;

    case (r_state)
      S_IDLE: begin
        w_cycle_nxt = '0;
        if (ld_req)    w_state_nxt = S_LOAD;
        else if (run)  w_state_nxt = S_RUN;
        else if (step) w_state_nxt = S_STEP;
      end

      // ld_req and step are deliberately not looked at while executing.
      S_RUN, S_STEP: begin
        if (state_in == ST_HALT) begin
          w_state_nxt = S_HALTED;
        end else if (state_in == ST_NEXT) begin
          w_cycle_nxt      = '0;
          w_instr_done_nxt = 1'b1;
          if (r_state == S_STEP || !run) w_state_nxt = S_IDLE;
        end else if (w_at_max) begin
          w_cycle_nxt   = '0;
          w_seq_err_nxt = 1'b1;
        end else begin
          w_cycle_nxt = r_cycle + CYCLE_W'(1);
        end
      end

      S_HALTED: begin
        if (ld_req) begin
          w_state_nxt = S_LOAD;
          w_cycle_nxt = '0;
        end
      end

      S_LOAD: begin
        w_cycle_nxt = '0;
        if (!ld_req) w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cycle_nxt = '0;
      end
    endcase
  end

  // Moore outputs are decoded from the next state so they line up with it.
  assign w_exec_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cycle      <= '0;
      r_cycle_en   <= 1'b0;
      r_instr_done <= 1'b0;
      r_halted     <= 1'b0;
      r_ld_gnt     <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cycle      <= w_cycle_nxt;
      r_cycle_en   <= w_exec_nxt;
      r_instr_done <= w_instr_done_nxt;
      r_halted     <= (w_state_nxt == S_HALTED);
      r_ld_gnt     <= (w_state_nxt == S_LOAD);
      r_seq_err    <= w_seq_err_nxt;
    end
  end

  assign cycle      = r_cycle;
  assign cycle_en   = r_cycle_en;
  assign instr_done = r_instr_done;
  assign halted     = r_halted;
  assign ld_gnt     = r_ld_gnt;
  assign seq_err    = r_seq_err;

  a_no_bus_conflict: assert property (@(posedge clk) disable iff (!reset_n)
    !(r_cycle_en && r_ld_gnt));
  a_halt_stops_exec: assert property (@(posedge clk) disable iff (!reset_n)
    !(r_halted && r_cycle_en));
  a_retire_at_zero: assert property (@(posedge clk) disable iff (!reset_n)
    r_instr_done |-> (r_cycle == '0));

endmodule
